// File: rtl/usb_capture_packer.sv
// ----------------------------------------------------------------------------
// usb_capture_packer
//
// Capture front-end for the USB sniffer. It watches the UTMI receive side and
// turns bus activity into 32-bit capture records held in a first-word-fall-
// through FIFO. The sniffer buffer drains the FIFO over a valid/ready stream.
//
// Record layout ([31:30] = type):
//   SOP  01 : [17:16] linestate, [15:0] timestamp
//   DATA 00 : [29:28] byte count 1..3, [23:0] bytes (first byte in [7:0])
//   EOP  10 : [29] rxerror seen, [28] record dropped, [15:0] packet byte count
//   LINE 11 : [17:16] new linestate, [15:0] timestamp
//
// Optional feature macro: USB_CAPTURE_LINESTATE_EN
//   When defined, a linestate change while idle and enabled emits a LINE
//   record. When undefined, linestate only appears in SOP records.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   enable_i              capture enable, sampled at packet start only
//   clear_i               clears overflow_o and drop_count_o
//   utmi_*_i              UTMI receive interface
//   outport_valid_o/ready_i/data_o   record stream (FIFO head)
//   overflow_o            sticky flag: a record was dropped
//   drop_count_o          saturating count of dropped records
// ----------------------------------------------------------------------------
module usb_capture_packer #(
  parameter int FIFO_DEPTH = 16,
  parameter int TS_DIV     = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        clear_i,
  input  logic [7:0]  utmi_data_in_i,
  input  logic        utmi_rxvalid_i,
  input  logic        utmi_rxactive_i,
  input  logic        utmi_rxerror_i,
  input  logic [1:0]  utmi_linestate_i,
  output logic        outport_valid_o,
  output logic [31:0] outport_data_o,
  input  logic        outport_ready_i,
  output logic        overflow_o,
  output logic [15:0] drop_count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] DIV_LAST = 16'(TS_DIV - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_EOP, ST_SKIP} state_t;

  state_t      r_state;
  logic [15:0] r_ts;
  logic [15:0] r_div_cnt;
  logic        r_rxactive_d;
  logic [15:0] r_byte_cnt;
  logic [15:0] r_pack;
  logic [1:0]  r_pack_cnt;
  logic        r_err_flag;
  logic        r_drop_flag;

  logic [31:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic        w_rise;
  logic        w_byte;
  logic        w_push;
  logic [31:0] w_push_data;
  logic        w_pop;
  logic        w_full;
  logic        w_accept;
  logic        w_drop;

  // --------------------------------------------------------------------------
  // Free-running timestamp with prescaler
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ts      <= 16'd0;
      r_div_cnt <= 16'd0;
    end else if (r_div_cnt == DIV_LAST) begin
      r_div_cnt <= 16'd0;
      r_ts      <= r_ts + 16'd1;
    end else begin
      r_div_cnt <= r_div_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_rxactive_d <= 1'b0;
    else       r_rxactive_d <= utmi_rxactive_i;
  end

`ifdef USB_CAPTURE_LINESTATE_EN
  logic [1:0] r_ls_prev;
  always_ff @(posedge clk_i) begin
    if (rst_i) r_ls_prev <= 2'b00;
    else       r_ls_prev <= utmi_linestate_i;
  end
`endif

  assign w_rise = utmi_rxactive_i & ~r_rxactive_d;
  assign w_byte = utmi_rxvalid_i & utmi_rxactive_i;

  // --------------------------------------------------------------------------
  // Record generation: at most one push per cycle
  // --------------------------------------------------------------------------
  always_comb begin
    w_push      = 1'b0;
    w_push_data = 32'd0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise && enable_i) begin
          w_push      = 1'b1;
          w_push_data = {2'b01, 12'd0, utmi_linestate_i, r_ts};
        end
`ifdef USB_CAPTURE_LINESTATE_EN
        else if (enable_i && !utmi_rxactive_i && (utmi_linestate_i != r_ls_prev)) begin
          w_push      = 1'b1;
          w_push_data = {2'b11, 12'd0, utmi_linestate_i, r_ts};
        end
`endif
      end
      ST_ACTIVE: begin
        if (!utmi_rxactive_i) begin
          w_push = 1'b1;
          if (r_pack_cnt != 2'd0)
            w_push_data = {2'b00, r_pack_cnt, 4'd0, 8'd0, r_pack};
          else
            // Error flag includes this cycle's rxerror since it is not yet registered
            w_push_data = {2'b10, r_err_flag | utmi_rxerror_i, r_drop_flag, 12'd0, r_byte_cnt};
        end else if (w_byte && r_pack_cnt == 2'd2) begin
          w_push      = 1'b1;
          w_push_data = {2'b00, 2'd3, 4'd0, utmi_data_in_i, r_pack};
        end
      end
      ST_EOP: begin
        w_push      = 1'b1;
        w_push_data = {2'b10, r_err_flag, r_drop_flag, 12'd0, r_byte_cnt};
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // FIFO control: a pop in the same cycle frees room for a push when full
  // --------------------------------------------------------------------------
  assign w_pop    = (r_count != '0) & outport_ready_i;
  assign w_full   = (r_count == DEPTH_L);
  assign w_accept = w_push & (~w_full | w_pop);
  assign w_drop   = w_push & ~w_accept;

  // --------------------------------------------------------------------------
  // Capture FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_byte_cnt  <= 16'd0;
      r_pack      <= 16'd0;
      r_pack_cnt  <= 2'd0;
      r_err_flag  <= 1'b0;
      r_drop_flag <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            if (enable_i) begin
              r_state     <= ST_ACTIVE;
              r_byte_cnt  <= 16'd0;
              r_pack      <= 16'd0;
              r_pack_cnt  <= 2'd0;
              r_err_flag  <= 1'b0;
              // A dropped SOP already counts against this packet
              r_drop_flag <= w_drop;
            end else begin
              r_state <= ST_SKIP;
            end
          end
        end
        ST_ACTIVE: begin
          if (utmi_rxerror_i) r_err_flag <= 1'b1;
          if (w_drop)         r_drop_flag <= 1'b1;
          if (!utmi_rxactive_i) begin
            r_state    <= (r_pack_cnt != 2'd0) ? ST_EOP : ST_IDLE;
            r_pack     <= 16'd0;
            r_pack_cnt <= 2'd0;
          end else if (w_byte) begin
            if (r_byte_cnt != 16'hFFFF) r_byte_cnt <= r_byte_cnt + 16'd1;
            if (r_pack_cnt == 2'd2) begin
              r_pack     <= 16'd0;
              r_pack_cnt <= 2'd0;
            end else begin
              if (r_pack_cnt == 2'd0) r_pack[7:0]  <= utmi_data_in_i;
              else                    r_pack[15:8] <= utmi_data_in_i;
              r_pack_cnt <= r_pack_cnt + 2'd1;
            end
          end
        end
        ST_EOP: begin
          r_state <= ST_IDLE;
        end
        ST_SKIP: begin
          if (!utmi_rxactive_i) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FIFO storage and pointers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (w_accept) r_mem[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign outport_valid_o = (r_count != '0);
  assign outport_data_o  = outport_valid_o ? r_mem[r_rd_ptr] : 32'd0;

  // --------------------------------------------------------------------------
  // Drop statistics; a clear wins over a coincident drop
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_o   <= 1'b0;
      drop_count_o <= 16'd0;
    end else if (clear_i) begin
      overflow_o   <= 1'b0;
      drop_count_o <= 16'd0;
    end else if (w_drop) begin
      overflow_o <= 1'b1;
      if (drop_count_o != 16'hFFFF) drop_count_o <= drop_count_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_usb_capture_packer.sv
// ----------------------------------------------------------------------------
// tb_usb_capture_packer
//
// Directed stimulus with a scoreboard: drivers push hand-computed expected
// records into a queue; an independent monitor pops and compares whenever the
// DUT hands over a record (valid & ready).
// ----------------------------------------------------------------------------
module tb_usb_capture_packer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic        clear_i;
  logic [7:0]  utmi_data_in_i;
  logic        utmi_rxvalid_i;
  logic        utmi_rxactive_i;
  logic        utmi_rxerror_i;
  logic [1:0]  utmi_linestate_i;
  logic        outport_valid_o;
  logic [31:0] outport_data_o;
  logic        outport_ready_i;
  logic        overflow_o;
  logic [15:0] drop_count_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [15:0] ts_model;

  usb_capture_packer #(.FIFO_DEPTH(16), .TS_DIV(1)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .enable_i         (enable_i),
    .clear_i          (clear_i),
    .utmi_data_in_i   (utmi_data_in_i),
    .utmi_rxvalid_i   (utmi_rxvalid_i),
    .utmi_rxactive_i  (utmi_rxactive_i),
    .utmi_rxerror_i   (utmi_rxerror_i),
    .utmi_linestate_i (utmi_linestate_i),
    .outport_valid_o  (outport_valid_o),
    .outport_data_o   (outport_data_o),
    .outport_ready_i  (outport_ready_i),
    .overflow_o       (overflow_o),
    .drop_count_o     (drop_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference timestamp: one tick per clock with TS_DIV=1
  always @(posedge clk_i) begin
    if (rst_i) ts_model <= 16'd0;
    else       ts_model <= ts_model + 16'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: compares each record as it is accepted
  always @(negedge clk_i) begin
    if (!rst_i && outport_valid_o && outport_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_record: got=%h expected=none", outport_data_o);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        $display("record got=%h exp=%h", outport_data_o, e);
        check("record", outport_data_o, e);
      end
    end
  end

  task automatic start_pkt();
    @(negedge clk_i);
    utmi_rxactive_i = 1'b1;
    utmi_rxvalid_i  = 1'b0;
    if (enable_i) exp_q.push_back({2'b01, 12'd0, utmi_linestate_i, ts_model});
  endtask

  task automatic send_byte(input logic [7:0] b, input logic err);
    @(negedge clk_i);
    utmi_rxvalid_i = 1'b1;
    utmi_data_in_i = b;
    utmi_rxerror_i = err;
  endtask

  task automatic end_pkt();
    @(negedge clk_i);
    utmi_rxvalid_i  = 1'b0;
    utmi_rxactive_i = 1'b0;
    utmi_rxerror_i  = 1'b0;
    repeat (3) @(negedge clk_i);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk_i);
    check({name, "_empty"}, {31'd0, outport_valid_o}, 32'd0);
  endtask

  initial begin
    rst_i            = 1'b1;
    enable_i         = 1'b1;
    clear_i          = 1'b0;
    utmi_data_in_i   = 8'h00;
    utmi_rxvalid_i   = 1'b0;
    utmi_rxactive_i  = 1'b0;
    utmi_rxerror_i   = 1'b0;
    utmi_linestate_i = 2'b00;
    outport_ready_i  = 1'b1;
    repeat (4) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    check("reset_valid", {31'd0, outport_valid_o}, 32'd0);
    check("reset_data", outport_data_o, 32'd0);
    check("reset_overflow", {31'd0, overflow_o}, 32'd0);
    check("reset_drop_count", {16'd0, drop_count_o}, 32'd0);

    // 1) five-byte packet
    start_pkt();
    exp_q.push_back(32'h3002_01C3);
    exp_q.push_back(32'h2000_0403);
    exp_q.push_back(32'h8000_0005);
    send_byte(8'hC3, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b0);
    end_pkt();
    drain("pkt5");

    // 2) exactly three bytes: no empty DATA record
    start_pkt();
    exp_q.push_back(32'h30FF_5AA5);
    exp_q.push_back(32'h8000_0003);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h5A, 1'b0);
    send_byte(8'hFF, 1'b0);
    end_pkt();
    drain("pkt3");

    // 4) rxerror on byte 2 of a four-byte packet
    start_pkt();
    exp_q.push_back(32'h3033_2211);
    exp_q.push_back(32'h1000_0044);
    exp_q.push_back(32'hA000_0004);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    end_pkt();
    drain("pkt_err");

    // 5) disabled at packet start, enabled mid-packet: packet ignored
    enable_i = 1'b0;
    start_pkt();
    send_byte(8'h99, 1'b0);
    enable_i = 1'b1;
    send_byte(8'h98, 1'b0);
    send_byte(8'h97, 1'b0);
    send_byte(8'h96, 1'b0);
    end_pkt();
    start_pkt();
    exp_q.push_back(32'h1000_00AB);
    exp_q.push_back(32'h8000_0001);
    send_byte(8'hAB, 1'b0);
    end_pkt();
    drain("pkt_skip");

    // 3) overflow: 20 records with the consumer stalled, only 16 are kept
    outport_ready_i = 1'b0;
    start_pkt();
    for (int k = 0; k < 15; k++) begin
      logic [7:0] b0;
      b0 = 8'(3 * k);
      exp_q.push_back({8'h30, b0 + 8'd2, b0 + 8'd1, b0});
    end
    for (int i = 0; i < 54; i++) send_byte(8'(i), 1'b0);
    end_pkt();
    check("ovf_drop_count", {16'd0, drop_count_o}, 32'd4);
    check("ovf_overflow", {31'd0, overflow_o}, 32'd1);
    check("ovf_valid", {31'd0, outport_valid_o}, 32'd1);
    check("ovf_head_sop_type", {30'd0, outport_data_o[31:30]}, 32'd1);
    @(negedge clk_i);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    check("clear_drop_count", {16'd0, drop_count_o}, 32'd0);
    check("clear_overflow", {31'd0, overflow_o}, 32'd0);
    outport_ready_i = 1'b1;
    drain("ovf");
    check("post_drain_drop_count", {16'd0, drop_count_o}, 32'd0);

    // 6) idle linestate changes
    @(negedge clk_i);
    utmi_linestate_i = 2'b01;
`ifdef USB_CAPTURE_LINESTATE_EN
    exp_q.push_back({2'b11, 12'd0, 2'b01, ts_model});
`endif
    repeat (3) @(negedge clk_i);
    utmi_linestate_i = 2'b00;
`ifdef USB_CAPTURE_LINESTATE_EN
    exp_q.push_back({2'b11, 12'd0, 2'b00, ts_model});
`endif
    repeat (3) @(negedge clk_i);
    drain("linestate");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
